// File: rtl/wb_pipe_stage.sv
// Writeback stage: selects and load-extracts the result, registers it, and drives the
// regfile write port one cycle after capture. Also provides forwarding data and a retire count.
module wb_pipe_stage #(
  parameter int unsigned XLEN  = 32,  // 32 or 64
  parameter int unsigned RA_W  = 5,
  parameter int unsigned CNT_W = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             hold,
  input  logic             flush,
  input  logic             reg_write,
  input  logic [RA_W-1:0]  rd,
  input  logic [1:0]       wb_sel,
  input  logic [XLEN-1:0]  alu_result,
  input  logic [XLEN-1:0]  pc_plus4,
  input  logic [XLEN-1:0]  imm,
  input  logic [XLEN-1:0]  mem_rdata,
  input  logic [2:0]       addr_lo,
  input  logic [2:0]       funct3,
  output logic             rf_we,
  output logic [RA_W-1:0]  rf_waddr,
  output logic [XLEN-1:0]  rf_wdata,
  output logic             fwd_valid,
  output logic [CNT_W-1:0] instret,
  output logic             load_misalign
);

  localparam int unsigned OffW = (XLEN == 64) ? 3 : 2;

  logic [OffW-1:0] off;
  logic [OffW-1:0] low_mask;
  logic [OffW-1:0] lane;
  logic [1:0]      size;
  logic            is_signed;
  logic            sign_bit;
  logic            misalign;
  logic [XLEN-1:0] shifted;
  logic [XLEN-1:0] keep_mask;
  logic [XLEN-1:0] load_data;
  logic [XLEN-1:0] sel_data;
  logic            misalign_d;
  logic            capture_v;

  logic             wb_v_q;
  logic             reg_write_q;
  logic [RA_W-1:0]  rd_q;
  logic [XLEN-1:0]  data_q;
  logic             load_misalign_q;
  logic [CNT_W-1:0] instret_q;

  // addr_lo[2] only selects a lane on a 64-bit datapath
  logic unused_addr_hi;
  assign unused_addr_hi = addr_lo[2];

  // Load lane extraction: misaligned accesses drop the low offset bits
  always_comb begin
    off  = addr_lo[OffW-1:0];
    size = funct3[1:0];
    if (XLEN == 32 && size == 2'd3) begin
      size = 2'd2;
    end
    is_signed = ~funct3[2];
    case (size)
      2'd0: begin
        low_mask  = '0;
        keep_mask = XLEN'(8'hff);
      end
      2'd1: begin
        low_mask  = OffW'(1);
        keep_mask = XLEN'(16'hffff);
      end
      2'd2: begin
        low_mask  = OffW'(3);
        keep_mask = XLEN'(32'hffff_ffff);
      end
      default: begin
        low_mask  = OffW'(7);
        keep_mask = '1;
      end
    endcase
    lane     = off & ~low_mask;
    misalign = (off & low_mask) != '0;
    shifted  = mem_rdata >> {lane, 3'b000};
    case (size)
      2'd0:    sign_bit = shifted[7];
      2'd1:    sign_bit = shifted[15];
      2'd2:    sign_bit = shifted[31];
      default: sign_bit = 1'b0;
    endcase
    load_data = (shifted & keep_mask) | ((is_signed & sign_bit) ? ~keep_mask : '0);
  end

  always_comb begin
    case (wb_sel)
      2'd0:    sel_data = alu_result;
      2'd1:    sel_data = load_data;
      2'd2:    sel_data = pc_plus4;
      default: sel_data = imm;
    endcase
    capture_v  = in_valid & ~flush;
    misalign_d = capture_v & (wb_sel == 2'd1) & misalign;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_v_q          <= 1'b0;
      reg_write_q     <= 1'b0;
      rd_q            <= '0;
      data_q          <= '0;
      load_misalign_q <= 1'b0;
      instret_q       <= '0;
    end else if (!hold) begin
      wb_v_q          <= capture_v;
      reg_write_q     <= reg_write;
      rd_q            <= rd;
      data_q          <= sel_data;
      load_misalign_q <= misalign_d;
      if (wb_v_q) begin
        instret_q <= instret_q + 1'b1;
      end
    end
  end

  assign in_ready      = ~hold;
  assign rf_we         = wb_v_q & reg_write_q & (rd_q != '0) & ~hold;
  assign rf_waddr      = rf_we ? rd_q : '0;
  assign rf_wdata      = rf_we ? data_q : '0;
  assign fwd_valid     = rf_we;
  assign instret       = instret_q;
  assign load_misalign = load_misalign_q;

endmodule

// File: tb/tb_wb_pipe_stage.sv
// Directed bench for wb_pipe_stage: a 32-bit instance driven from a vector table plus
// hand sequences, and a 64-bit instance with a 3-bit retire counter for wrap checks.
module tb_wb_pipe_stage;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // 32-bit instance
  logic        in_valid, hold, flush, reg_write;
  logic [4:0]  rd;
  logic [1:0]  wb_sel;
  logic [31:0] alu_result, pc_plus4, imm, mem_rdata;
  logic [2:0]  addr_lo, funct3;
  logic        in_ready, rf_we, fwd_valid, load_misalign;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic [63:0] instret;

  wb_pipe_stage #(.XLEN(32), .RA_W(5), .CNT_W(64)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .hold(hold),
    .flush(flush), .reg_write(reg_write), .rd(rd), .wb_sel(wb_sel), .alu_result(alu_result),
    .pc_plus4(pc_plus4), .imm(imm), .mem_rdata(mem_rdata), .addr_lo(addr_lo), .funct3(funct3),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .fwd_valid(fwd_valid),
    .instret(instret), .load_misalign(load_misalign)
  );

  // 64-bit instance
  logic        b_in_valid, b_hold, b_flush, b_reg_write;
  logic [4:0]  b_rd;
  logic [1:0]  b_wb_sel;
  logic [63:0] b_alu_result, b_pc_plus4, b_imm, b_mem_rdata;
  logic [2:0]  b_addr_lo, b_funct3;
  logic        b_in_ready, b_rf_we, b_fwd_valid, b_load_misalign;
  logic [4:0]  b_rf_waddr;
  logic [63:0] b_rf_wdata;
  logic [2:0]  b_instret;

  wb_pipe_stage #(.XLEN(64), .RA_W(5), .CNT_W(3)) dut64 (
    .clk(clk), .rst_n(rst_n), .in_valid(b_in_valid), .in_ready(b_in_ready), .hold(b_hold),
    .flush(b_flush), .reg_write(b_reg_write), .rd(b_rd), .wb_sel(b_wb_sel),
    .alu_result(b_alu_result), .pc_plus4(b_pc_plus4), .imm(b_imm), .mem_rdata(b_mem_rdata),
    .addr_lo(b_addr_lo), .funct3(b_funct3), .rf_we(b_rf_we), .rf_waddr(b_rf_waddr),
    .rf_wdata(b_rf_wdata), .fwd_valid(b_fwd_valid), .instret(b_instret),
    .load_misalign(b_load_misalign)
  );

  typedef struct {
    logic [1:0]  sel;
    logic [2:0]  f3;
    logic [2:0]  alo;
    logic [31:0] rdata;
    logic [31:0] src;
    logic [4:0]  rd;
    logic        rw;
    logic        exp_we;
    logic [31:0] exp_data;
    logic        exp_mis;
  } vec_t;

  localparam int NVec = 18;
  vec_t vecs[NVec];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [1:0] sel, input logic [2:0] f3, input logic [2:0] alo,
                              input logic [31:0] rdata, input logic [31:0] src,
                              input logic [4:0] r, input logic rw, input logic we,
                              input logic [31:0] d, input logic mis);
    vec_t v;
    v.sel = sel; v.f3 = f3; v.alo = alo; v.rdata = rdata; v.src = src;
    v.rd = r; v.rw = rw; v.exp_we = we; v.exp_data = d; v.exp_mis = mis;
    return v;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Put src on the selected source; other sources carry distinct junk
  task automatic drive_a(input vec_t v);
    wb_sel     = v.sel;
    funct3     = v.f3;
    addr_lo    = v.alo;
    mem_rdata  = v.rdata;
    alu_result = (v.sel == 2'd0) ? v.src : 32'hA5A5_0001;
    pc_plus4   = (v.sel == 2'd2) ? v.src : 32'hA5A5_0002;
    imm        = (v.sel == 2'd3) ? v.src : 32'hA5A5_0003;
    rd         = v.rd;
    reg_write  = v.rw;
  endtask

  task automatic drive_b(input logic [1:0] sel, input logic [2:0] f3, input logic [2:0] alo,
                         input logic [63:0] rdata, input logic [63:0] alu);
    b_in_valid = 1'b1; b_wb_sel = sel; b_funct3 = f3; b_addr_lo = alo;
    b_mem_rdata = rdata; b_alu_result = alu;
  endtask

  logic [63:0] ibase;

  initial begin
    vecs[0]  = mk(2'd0, 3'b000, 3'd0, 32'h0,         32'h0000_1234, 5'd5,  1, 1, 32'h0000_1234, 0);
    vecs[1]  = mk(2'd1, 3'b000, 3'd3, 32'h80FF_7F80, 32'h0,         5'd10, 1, 1, 32'hFFFF_FF80, 0);
    vecs[2]  = mk(2'd1, 3'b100, 3'd3, 32'h80FF_7F80, 32'h0,         5'd11, 1, 1, 32'h0000_0080, 0);
    vecs[3]  = mk(2'd1, 3'b001, 3'd2, 32'h80FF_7F80, 32'h0,         5'd12, 1, 1, 32'hFFFF_80FF, 0);
    vecs[4]  = mk(2'd1, 3'b101, 3'd2, 32'h80FF_7F80, 32'h0,         5'd13, 1, 1, 32'h0000_80FF, 0);
    vecs[5]  = mk(2'd1, 3'b000, 3'd1, 32'h80FF_7F80, 32'h0,         5'd14, 1, 1, 32'h0000_007F, 0);
    vecs[6]  = mk(2'd1, 3'b001, 3'd0, 32'h80FF_7F80, 32'h0,         5'd15, 1, 1, 32'h0000_7F80, 0);
    vecs[7]  = mk(2'd1, 3'b010, 3'd1, 32'h80FF_7F80, 32'h0,         5'd16, 1, 1, 32'h80FF_7F80, 1);
    vecs[8]  = mk(2'd0, 3'b010, 3'd1, 32'h80FF_7F80, 32'hDEAD_BEEF, 5'd31, 1, 1, 32'hDEAD_BEEF, 0);
    vecs[9]  = mk(2'd1, 3'b001, 3'd3, 32'h80FF_7F80, 32'h0,         5'd17, 1, 1, 32'hFFFF_80FF, 1);
    vecs[10] = mk(2'd2, 3'b010, 3'd1, 32'h80FF_7F80, 32'h0000_0104, 5'd1,  1, 1, 32'h0000_0104, 0);
    vecs[11] = mk(2'd3, 3'b000, 3'd0, 32'h0,         32'h1234_5000, 5'd7,  1, 1, 32'h1234_5000, 0);
    vecs[12] = mk(2'd0, 3'b000, 3'd0, 32'h0,         32'hCAFE_0000, 5'd9,  0, 0, 32'h0,         0);
    vecs[13] = mk(2'd0, 3'b000, 3'd0, 32'h0,         32'hCAFE_0001, 5'd0,  1, 0, 32'h0,         0);
    vecs[14] = mk(2'd1, 3'b011, 3'd0, 32'h80FF_7F80, 32'h0,         5'd18, 1, 1, 32'h80FF_7F80, 0);
    vecs[15] = mk(2'd1, 3'b011, 3'd2, 32'h80FF_7F80, 32'h0,         5'd19, 1, 1, 32'h80FF_7F80, 1);
    vecs[16] = mk(2'd1, 3'b110, 3'd0, 32'h80FF_7F80, 32'h0,         5'd20, 1, 1, 32'h80FF_7F80, 0);
    vecs[17] = mk(2'd1, 3'b100, 3'd0, 32'h80FF_7F80, 32'h0,         5'd21, 1, 1, 32'h0000_0080, 0);

    in_valid = 0; hold = 0; flush = 0;
    drive_a(vecs[0]);
    b_in_valid = 0; b_hold = 0; b_flush = 0; b_reg_write = 1; b_rd = 5'd3;
    b_wb_sel = 0; b_alu_result = '0; b_pc_plus4 = 64'h1; b_imm = 64'h2; b_mem_rdata = '0;
    b_addr_lo = 0; b_funct3 = 0;

    // Reset state
    #12;
    check("reset rf_we", {63'd0, rf_we}, 64'd0);
    check("reset rf_waddr", {59'd0, rf_waddr}, 64'd0);
    check("reset rf_wdata", {32'd0, rf_wdata}, 64'd0);
    check("reset instret", instret, 64'd0);
    check("reset load_misalign", {63'd0, load_misalign}, 64'd0);
    @(negedge clk); rst_n = 1;
    step();
    check("idle in_ready", {63'd0, in_ready}, 64'd1);

    // Table: one instruction per cycle, each checked the cycle after capture
    for (int i = 0; i < NVec; i++) begin
      @(negedge clk);
      in_valid = 1;
      drive_a(vecs[i]);
      step();
      check($sformatf("vec%0d rf_we", i), {63'd0, rf_we}, {63'd0, vecs[i].exp_we});
      check($sformatf("vec%0d fwd_valid", i), {63'd0, fwd_valid}, {63'd0, vecs[i].exp_we});
      check($sformatf("vec%0d rf_waddr", i), {59'd0, rf_waddr},
            {59'd0, vecs[i].exp_we ? vecs[i].rd : 5'd0});
      check($sformatf("vec%0d rf_wdata", i), {32'd0, rf_wdata}, {32'd0, vecs[i].exp_data});
      check($sformatf("vec%0d misalign", i), {63'd0, load_misalign}, {63'd0, vecs[i].exp_mis});
    end
    @(negedge clk); in_valid = 0;
    step();
    check("table instret", instret, 64'(NVec));
    check("idle rf_we", {63'd0, rf_we}, 64'd0);

    // rd=0 write, then in_valid with flush: bubble
    ibase = instret;
    @(negedge clk); in_valid = 1; drive_a(vecs[13]);
    step();
    check("rd0 rf_we", {63'd0, rf_we}, 64'd0);
    @(negedge clk); flush = 1; drive_a(vecs[0]);
    step();
    check("flush rf_we", {63'd0, rf_we}, 64'd0);
    check("rd0 retires", instret, ibase + 64'd1);
    @(negedge clk); in_valid = 0; flush = 0;
    step();
    check("bubble no retire", instret, ibase + 64'd1);

    // Hold over a captured JAL; flush during hold is ignored
    ibase = instret;
    @(negedge clk); in_valid = 1; drive_a(vecs[10]);
    step();
    hold = 1; in_valid = 1; flush = 1; drive_a(vecs[0]);
    #1;
    check("hold in_ready", {63'd0, in_ready}, 64'd0);
    for (int c = 0; c < 3; c++) begin
      check($sformatf("hold%0d rf_we", c), {63'd0, rf_we}, 64'd0);
      check($sformatf("hold%0d rf_wdata", c), {32'd0, rf_wdata}, 64'd0);
      step();
    end
    check("hold instret", instret, ibase);
    @(negedge clk); hold = 0; in_valid = 0; flush = 0;
    #1;
    check("release rf_we", {63'd0, rf_we}, 64'd1);
    check("release rf_waddr", {59'd0, rf_waddr}, 64'd1);
    check("release rf_wdata", {32'd0, rf_wdata}, 64'h104);
    step();
    check("release single write", {63'd0, rf_we}, 64'd0);
    check("release instret", instret, ibase + 64'd1);

    // Reset while holding a misaligned load
    @(negedge clk); in_valid = 1; drive_a(vecs[7]);
    step();
    hold = 1; in_valid = 0;
    #1;
    check("prereset misalign", {63'd0, load_misalign}, 64'd1);
    #2 rst_n = 0;
    #1;
    check("midhold rst rf_we", {63'd0, rf_we}, 64'd0);
    check("midhold rst rf_waddr", {59'd0, rf_waddr}, 64'd0);
    check("midhold rst rf_wdata", {32'd0, rf_wdata}, 64'd0);
    check("midhold rst instret", instret, 64'd0);
    check("midhold rst misalign", {63'd0, load_misalign}, 64'd0);
    @(negedge clk); rst_n = 1;
    @(negedge clk); hold = 0;
    #1;
    check("post rst no write", {63'd0, rf_we}, 64'd0);
    step();
    check("post rst instret", instret, 64'd0);

    // 64-bit extraction and 3-bit counter wrap
    @(negedge clk); drive_b(2'd1, 3'b110, 3'd4, 64'hFFFF_FFFF_1234_5678, 64'h0);
    step();
    check("x64 LWU", b_rf_wdata, 64'h0000_0000_FFFF_FFFF);
    @(negedge clk); drive_b(2'd1, 3'b010, 3'd4, 64'hFFFF_FFFF_1234_5678, 64'h0);
    step();
    check("x64 LW", b_rf_wdata, 64'hFFFF_FFFF_FFFF_FFFF);
    @(negedge clk); drive_b(2'd1, 3'b010, 3'd0, 64'hFFFF_FFFF_1234_5678, 64'h0);
    step();
    check("x64 LW lo", b_rf_wdata, 64'h0000_0000_1234_5678);
    @(negedge clk); drive_b(2'd1, 3'b011, 3'd0, 64'hFFFF_FFFF_1234_5678, 64'h0);
    step();
    check("x64 LD", b_rf_wdata, 64'hFFFF_FFFF_1234_5678);
    check("x64 LD aligned", {63'd0, b_load_misalign}, 64'd0);
    @(negedge clk); drive_b(2'd1, 3'b011, 3'd4, 64'hFFFF_FFFF_1234_5678, 64'h0);
    step();
    check("x64 LD mis data", b_rf_wdata, 64'hFFFF_FFFF_1234_5678);
    check("x64 LD mis flag", {63'd0, b_load_misalign}, 64'd1);
    @(negedge clk); drive_b(2'd1, 3'b100, 3'd5, 64'hFFFF_FFFF_1234_5678, 64'h0);
    step();
    check("x64 LBU", b_rf_wdata, 64'h0000_0000_0000_00FF);
    @(negedge clk); drive_b(2'd0, 3'b011, 3'd4, 64'h0, 64'h0123_4567_89AB_CDEF);
    step();
    check("x64 ALU", b_rf_wdata, 64'h0123_4567_89AB_CDEF);
    check("x64 ALU clears misalign", {63'd0, b_load_misalign}, 64'd0);
    @(negedge clk); b_in_valid = 0;
    step(); step();
    check("x64 instret all ones", {61'd0, b_instret}, 64'd7);
    @(negedge clk); drive_b(2'd1, 3'b000, 3'd0, 64'hFFFF_FFFF_1234_5678, 64'h0);
    step();
    check("x64 LB", b_rf_wdata, 64'h0000_0000_0000_0078);
    @(negedge clk); b_in_valid = 0;
    step(); step();
    check("x64 instret wrap", {61'd0, b_instret}, 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule
